// File: rtl/fir_mac_core.sv
// Time-multiplexed 8-tap FIR: one multiplier walks the delay line once per accepted sample,
// then rounds and saturates the accumulator onto a held output with a one-cycle valid pulse.
module fir_mac_core #(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int TAPS      = 8,
    parameter int ACC_W     = 20,
    parameter int OUT_SHIFT = 6,
    localparam int AW       = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_sample,
    output logic                     in_ready,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_sample,
    output logic                     busy
);

    localparam int PW = DATA_W + COEF_W;
    localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1) << (OUT_SHIFT - 1);
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(2 ** (DATA_W - 1)));
    localparam logic [AW-1:0]           LAST    = AW'(TAPS - 1);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [AW-1:0]             idx_q, idx_d;
    logic signed [DATA_W-1:0]  x_q [TAPS];
    logic signed [DATA_W-1:0]  x_d [TAPS];
    logic signed [COEF_W-1:0]  coef_q [TAPS];
    logic signed [COEF_W-1:0]  coef_d [TAPS];
    logic signed [DATA_W-1:0]  out_sample_q, out_sample_d;
    logic                      out_valid_q, out_valid_d;

    logic signed [PW-1:0]      prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   rnd;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [DATA_W-1:0]  sat;
    logic                      addr_ok;

    assign prod     = coef_q[idx_q] * x_q[idx_q];
    assign prod_ext = {{(ACC_W - PW){prod[PW-1]}}, prod};
    assign rnd      = acc_q + HALF;
    assign shifted  = rnd >>> OUT_SHIFT;
    assign addr_ok  = 32'(coef_addr) < TAPS;

    assign in_ready   = ena && (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign out_valid  = out_valid_q;
    assign out_sample = out_sample_q;

    always_comb begin
        if (shifted > OUT_MAX) begin
            sat = OUT_MAX[DATA_W-1:0];
        end else if (shifted < OUT_MIN) begin
            sat = OUT_MIN[DATA_W-1:0];
        end else begin
            sat = shifted[DATA_W-1:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        x_d          = x_q;
        coef_d       = coef_q;
        out_sample_d = out_sample_q;
        out_valid_d  = 1'b0;

        if (ena) begin
            // Applied before the shift so a same-edge sample uses the new coefficient.
            if (coef_we && (state_q == IDLE) && addr_ok) begin
                coef_d[coef_addr] = coef_data;
            end
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 1; i < TAPS; i++) begin
                            x_d[i] = x_q[i-1];
                        end
                        x_d[0]  = in_sample;
                        acc_d   = '0;
                        idx_d   = '0;
                        state_d = MAC;
                    end
                end
                MAC: begin
                    acc_d = acc_q + prod_ext;
                    idx_d = idx_q + AW'(1);
                    if (idx_q == LAST) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    out_sample_d = sat;
                    out_valid_d  = 1'b1;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            idx_q        <= '0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i]    <= '0;
                coef_q[i] <= '0;
            end
            coef_q[0] <= COEF_W'(1 << OUT_SHIFT);
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i]    <= x_d[i];
                coef_q[i] <= coef_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_core.sv
// Randomized bench for fir_mac_core: every accepted sample is checked against a plain
// integer convolution of the sample history with the coefficient table.
module tb_fir_mac_core;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ena = 1'b0;
    logic              in_valid = 1'b0;
    logic signed [7:0] in_sample = '0;
    logic              in_ready;
    logic              coef_we = 1'b0;
    logic [2:0]        coef_addr = '0;
    logic signed [7:0] coef_data = '0;
    logic              out_valid;
    logic signed [7:0] out_sample;
    logic              busy;

    int checks = 0;
    int failures = 0;
    int mcoef [8];
    int mx [8];

    fir_mac_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .in_valid   (in_valid),
        .in_sample  (in_sample),
        .in_ready   (in_ready),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .out_valid  (out_valid),
        .out_sample (out_sample),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetModel();
        for (int i = 0; i < 8; i++) begin
            mcoef[i] = 0;
            mx[i]    = 0;
        end
        mcoef[0] = 64;
    endtask

    // Round half up after dividing by 64, then clamp to the signed 8-bit range.
    function automatic int modelResult();
        int sum = 0;
        int r;
        for (int i = 0; i < 8; i++) sum += mcoef[i] * mx[i];
        r = (sum + 32) >>> 6;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    task automatic writeCoef(input int addr, input int data);
        logic signed [7:0] d8;
        d8        = data[7:0];
        coef_we   = 1'b1;
        coef_addr = addr[2:0];
        coef_data = d8;
        tick();
        coef_we = 1'b0;
        mcoef[addr] = d8;
    endtask

    // wrAt: -1 none, 0 write on the accept edge (takes effect), >0 write on MAC edge wrAt (dropped).
    task automatic applyStimulus(input int s, input int stallLen, input int wrAt,
                                 input int wrAddr, input int wrData);
        int n;
        int firstE;
        int pulses;
        int expV;
        int lat;
        logic signed [7:0] s8;
        logic signed [7:0] d8;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        checkOutput("in_ready_before_accept", int'(in_ready), 1);
        s8 = s[7:0];
        d8 = wrData[7:0];
        in_valid  = 1'b1;
        in_sample = s8;
        if (wrAt == 0) begin
            coef_we   = 1'b1;
            coef_addr = wrAddr[2:0];
            coef_data = d8;
            mcoef[wrAddr] = d8;
        end
        for (int i = 7; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = s8;
        expV = modelResult();
        tick();
        in_valid = 1'b0;
        coef_we  = 1'b0;
        lat    = 9 + stallLen;
        firstE = -1;
        pulses = 0;
        for (int e = 1; e <= lat + 3; e++) begin
            ena       = !(stallLen > 0 && e > 4 && e <= 4 + stallLen);
            coef_we   = (wrAt > 0 && e == wrAt);
            coef_addr = wrAddr[2:0];
            coef_data = d8;
            tick();
            if (out_valid) begin
                pulses++;
                if (firstE < 0) firstE = e;
            end
            if (e == 4) begin
                checkOutput("in_ready_low_during_mac", int'(in_ready), 0);
                checkOutput("busy_during_mac", int'(busy), 1);
            end
        end
        coef_we = 1'b0;
        ena     = 1'b1;
        checkOutput("out_valid_latency", firstE, lat);
        checkOutput("out_valid_pulses", pulses, 1);
        checkOutput("out_sample_value", int'(out_sample), expV);
    endtask

    initial begin
        int s;
        int r;
        resetModel();
        rst_n = 1'b0;
        ena   = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        checkOutput("reset_out_sample", int'(out_sample), 0);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_in_ready", int'(in_ready), 1);
        ena = 1'b0;
        #1;
        checkOutput("in_ready_ena_low", int'(in_ready), 0);
        ena = 1'b1;
        tick();

        applyStimulus(100, 0, -1, 0, 0);
        applyStimulus(-50, 0, -1, 0, 0);
        applyStimulus(0, 0, -1, 0, 0);

        for (int i = 0; i < 8; i++) writeCoef(i, 8);
        for (int i = 0; i < 8; i++) applyStimulus(80, 0, -1, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, -1, 0, 0);

        writeCoef(0, 1);
        for (int i = 1; i < 8; i++) writeCoef(i, 0);
        applyStimulus(32, 0, -1, 0, 0);
        applyStimulus(31, 0, -1, 0, 0);
        applyStimulus(-32, 0, -1, 0, 0);
        applyStimulus(-33, 0, -1, 0, 0);

        for (int i = 0; i < 8; i++) writeCoef(i, 127);
        for (int i = 0; i < 8; i++) applyStimulus(127, 0, -1, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(-128, 0, -1, 0, 0);

        for (int i = 0; i < 8; i++) writeCoef(i, 3 * i - 10);
        applyStimulus(50, 0, 3, 0, -100);
        applyStimulus(20, 0, -1, 0, 0);
        applyStimulus(-30, 5, -1, 0, 0);
        applyStimulus(10, 0, 0, 1, -7);

        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                writeCoef(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)) - 128);
            end
            s = int'($urandom_range(0, 255)) - 128;
            r = int'($urandom_range(0, 5));
            if (r == 0) begin
                applyStimulus(s, int'($urandom_range(1, 4)), -1, 0, 0);
            end else if (r == 1) begin
                applyStimulus(s, 0, 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)) - 128);
            end else if (r == 2) begin
                applyStimulus(s, 0, int'($urandom_range(2, 8)), int'($urandom_range(0, 7)),
                              int'($urandom_range(0, 255)) - 128);
            end else begin
                applyStimulus(s, 0, -1, 0, 0);
            end
        end

        // Abandon a MAC partway through with a one-cycle reset.
        writeCoef(0, 5);
        writeCoef(3, -9);
        in_valid  = 1'b1;
        in_sample = 8'sd55;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        r = 0;
        for (int e = 0; e < 14; e++) begin
            if (out_valid) r++;
            tick();
        end
        checkOutput("reset_mid_mac_no_valid", r, 0);
        checkOutput("reset_mid_mac_out_sample", int'(out_sample), 0);
        checkOutput("reset_mid_mac_busy", int'(busy), 0);
        resetModel();
        applyStimulus(100, 0, -1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
